// File: rtl/cpu8_core.sv
// cpu8_core: 8-bit accumulator CPU that initiates transfers on the shared 8-bit memory bus.
// Instructions run as FETCH -> (OPERAND) -> (EXEC) steps; HLT parks the core until reset.
module cpu8_core #(
  parameter logic [7:0] RESET_PC = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] address_bus,
  output logic       write_enable,
  output logic [7:0] to_mem,
  input  logic [7:0] from_mem,
  output logic [7:0] acc,
  output logic [7:0] pc,
  output logic       halted
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_OPERAND = 2'd1,
    S_EXEC    = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LDA = 4'h2,
    OP_STA = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_JMP = 4'h8,
    OP_JZ  = 4'h9,
    OP_JC  = 4'hA,
    OP_HLT = 4'hF
  } opcode_t;

  state_t     r_state;
  logic [7:0] r_pc;
  logic [3:0] r_ir;   // only the opcode nibble of IR ever influences behaviour
  logic [7:0] r_opr;
  logic [7:0] r_a;
  logic       r_z;
  logic       r_c;

  logic [3:0] w_fetch_op;
  logic       w_two_byte;
  logic       w_mem_op;
  logic       w_taken;
  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic [7:0] w_and;

  assign w_fetch_op = from_mem[7:4];
  assign w_sum      = {1'b0, r_a} + {1'b0, from_mem};
  assign w_diff     = {1'b0, r_a} - {1'b0, from_mem};  // bit 8 is the borrow
  assign w_and      = r_a & from_mem;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_two_byte = 1'b0;
    case (w_fetch_op)
      OP_LDI, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND,
      OP_JMP, OP_JZ, OP_JC: w_two_byte = 1'b1;
      default:              w_two_byte = 1'b0;
    endcase
  end

  always_comb begin
    w_mem_op = 1'b0;
    w_taken  = 1'b0;
    case (r_ir)
      OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND: w_mem_op = 1'b1;
      OP_JMP:  w_taken = 1'b1;
      OP_JZ:   w_taken = r_z;
      OP_JC:   w_taken = r_c;
      default: begin
        w_mem_op = 1'b0;
        w_taken  = 1'b0;
      end
    endcase
  end

  // The bus follows the state register directly, so reset silences a pending STA at once.
  assign address_bus  = (r_state == S_EXEC) ? r_opr : r_pc;
  assign write_enable = (r_state == S_EXEC) && (r_ir == OP_STA);
  assign to_mem       = r_a;
  assign acc          = r_a;
  assign pc           = r_pc;
  assign halted       = (r_state == S_HALT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 4'h0;
      r_opr   <= 8'h00;
      r_a     <= 8'h00;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir <= w_fetch_op;
          r_pc <= r_pc + 8'd1;
          if (w_fetch_op == OP_HLT) begin
            r_state <= S_HALT;
          end else if (w_two_byte) begin
            r_state <= S_OPERAND;
          end else begin
            r_state <= S_FETCH;
          end
        end

        S_OPERAND: begin
          r_opr <= from_mem;
          r_pc  <= w_taken ? from_mem : r_pc + 8'd1;
          if (r_ir == OP_LDI) begin
            r_a <= from_mem;
            r_z <= (from_mem == 8'h00);
          end
          r_state <= w_mem_op ? S_EXEC : S_FETCH;
        end

        S_EXEC: begin
          case (r_ir)
            OP_LDA: begin
              r_a <= from_mem;
              r_z <= (from_mem == 8'h00);
            end
            OP_ADD: begin
              r_a <= w_sum[7:0];
              r_c <= w_sum[8];
              r_z <= (w_sum[7:0] == 8'h00);
            end
            OP_SUB: begin
              r_a <= w_diff[7:0];
              r_c <= w_diff[8];
              r_z <= (w_diff[7:0] == 8'h00);
            end
            OP_AND: begin
              r_a <= w_and;
              r_z <= (w_and == 8'h00);
            end
            default: begin
              r_a <= r_a;
            end
          endcase
          r_state <= S_FETCH;
        end

        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/cpu8_core.md
# cpu8_core

Minimal 8-bit accumulator CPU that acts as the bus initiator for the team's 8-bit `memory` block. It fetches instructions and operands over the shared 8-bit address bus, reads data combinationally from memory, and issues single-cycle writes. Address space: 0x00–0x7F is RAM and 0x80–0xFF is ROM. Execution starts at 0x80.

## Interface
Parameters:
- RESET_PC, 8'h80, PC value loaded on reset (start of ROM).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address_bus  out  8  memory address; combinational from state.
- write_enable  out  1  memory write strobe; memory captures on the next rising clk.
- to_mem  out  8  write data; always equals the accumulator.
- from_mem  in  8  combinational read data for address_bus.
- acc  out  8  accumulator (debug).
- pc  out  8  program counter (debug).
- halted  out  1  high once HLT has executed.

## Operation
- Registers: PC[7:0], IR[7:0], OPR[7:0], A[7:0], flags Z and C, and a state register.
- Opcode is IR[7:4]; IR[3:0] is ignored. Two-byte instructions carry an operand byte at PC+1.
- Opcode map:
  - 0x0 NOP (1 byte).
  - 0x1 LDI imm: A=imm.
  - 0x2 LDA a: A=M[a].
  - 0x3 STA a: M[a]=A.
  - 0x4 ADD a: A=A+M[a]; C=carry-out of the 9-bit sum.
  - 0x5 SUB a: A=A−M[a], mod 256; C=1 when A<M[a] (borrow).
  - 0x6 AND a: A=A&M[a].
  - 0x8 JMP a: PC=a.
  - 0x9 JZ a: PC=a if Z=1.
  - 0xA JC a: PC=a if C=1.
  - 0xF HLT (1 byte).
  - 0x7, 0xB–0xE are undefined and execute as a 1-byte NOP.
- Flag updates:
  - Z=(new A==0) after LDI, LDA, ADD, SUB, AND.
  - C changes only on ADD and SUB.
  - All other instructions leave both flags unchanged.
- States:
  - FETCH
    - address_bus=PC; IR<=from_mem; PC<=PC+1.
    - Next state is decoded from from_mem: NOP/undefined → FETCH, HLT → HALT, else → OPERAND.
  - OPERAND
    - address_bus=PC; OPR<=from_mem; PC<=PC+1.
    - LDI and jumps complete in this state: A, Z or PC are updated from from_mem. A taken jump overrides PC+1. Next → FETCH.
    - LDA/STA/ADD/SUB/AND → EXEC.
  - EXEC
    - address_bus=OPR.
    - Reads capture from_mem into the ALU result.
    - STA drives write_enable=1 for exactly this one cycle.
    - Next → FETCH.
  - HALT
    - address_bus=PC; write_enable=0; halted=1.
    - No state change until reset.
- PC arithmetic is mod 256: 0xFF+1=0x00, and fetching continues into RAM.
- The core does not filter addresses. STA to any address is issued as-is.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-instruction):
  - state=FETCH, PC=RESET_PC, A=0, Z=0, C=0, IR=0, OPR=0.
  - Outputs: address_bus=0x80, write_enable=0, to_mem=0, acc=0, pc=0x80, halted=0.
  - A STA interrupted by reset produces no write strobe.
- First fetch occurs on the first rising clk after reset deasserts.
- Instruction latency:
  - NOP/undefined: 1 cycle.
  - HLT: 1 cycle; halted rises after that edge.
  - LDI/JMP/JZ/JC: 2 cycles, taken or not.
  - LDA/STA/ADD/SUB/AND: 3 cycles.
- write_enable is high only in STA's EXEC cycle, with address_bus=OPR and to_mem=A stable for the whole cycle. It is never high in FETCH, OPERAND or HALT.
- A load followed by a store to the same address needs no stall. STA's write lands at the edge ending EXEC, and the next read of that address sees the new value.

## Test plan
- Reset: assert reset mid-EXEC of STA → address_bus=0x80, write_enable=0, acc=0, halted=0 immediately; no RAM write occurs.
- Straight-line program:
  - Setup: ROM 0x80: 10 05 40 10 30 20 F0; RAM[0x10]=0xFC.
  - Expected: after 9 clocks, halted=1; RAM[0x20]=0x01, acc=0x01, C=1, Z=0, pc=0x87.
- Loop:
  - Setup: ROM 0x80: 10 03 50 11 90 88 80 82 F0; RAM[0x11]=0x01.
  - Expected: exactly 3 SUB executions; halts with acc=0x00, Z=1, pc=0x89.
- Write strobe check: STA 0x3C with A=0xA5 → write_enable high for exactly one cycle with address_bus=0x3C and to_mem=0xA5; RAM[0x3C]=0xA5.
- PC wrap:
  - Setup: 0x80: 80 FF (JMP 0xFF); ROM 0xFF=0x00; RAM[0x00]=0xF0.
  - Expected: address_bus sequence 0x80, 0x81, 0xFF, 0x00; halts with pc=0x01.
- Undefined opcode and flag preservation:
  - Setup: ROM 0x80: B7 A0 84 F0 with C=0; then ROM 0x84: F0.
  - Expected: B7 takes 1 cycle as a NOP and does not change the flags; JC is not taken (pc advances to 0x83) and the core halts at 0x83.
